// File: rtl/booth_pkg.sv
// booth_pkg
//   Shared constants and types for the Booth multiply/accumulate slice.
//   - BOOTH_IN_W / BOOTH_PROD_W : multiplier operand and product widths.
//   - BOOTH_OUT_MAX / BOOTH_OUT_MIN : signed 64-bit saturation limits.
//   - state_t : accumulator FSM state (IDLE, ACCUM, OUT).
package booth_pkg;

  localparam int BOOTH_IN_W   = 32;
  localparam int BOOTH_PROD_W = 64;

  localparam logic [63:0] BOOTH_OUT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] BOOTH_OUT_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/booth_acc_narrow.sv
// booth_acc_narrow
//   Combinational narrowing of the wide accumulator to the emitted result.
//   Optional macro: BOOTH_MAC_SAT_EN (saturate on overflow instead of truncate).
//   Ports:
//     i_acc    [ACC_W-1:0]  accumulator value (two's complement)
//     i_wrap                sticky flag: accumulator add overflowed ACC_W
//     o_result [OUT_W-1:0]  narrowed result
//     o_ovf                 result not exactly representable in OUT_W
module booth_acc_narrow
  import booth_pkg::*;
#(
  parameter int ACC_W = 80,
  parameter int OUT_W = 64
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic             i_wrap,
  output logic [OUT_W-1:0] o_result,
  output logic             o_ovf
);

  logic w_range_ovf;

  // In range iff every bit from ACC_W-1 down to OUT_W-1 equals the sign bit.
  generate
    if (ACC_W > OUT_W) begin : g_range
      logic [ACC_W-OUT_W:0] w_top;
      assign w_top       = i_acc[ACC_W-1:OUT_W-1];
      assign w_range_ovf = !((&w_top) || !(|w_top));
    end else begin : g_no_range
      assign w_range_ovf = 1'b0;
    end
  endgenerate

  assign o_ovf = i_wrap | w_range_ovf;

`ifdef BOOTH_MAC_SAT_EN
  // A wrapped accumulator has the wrong sign bit, so the true sign is
  // the MSB flipped by the wrap flag.
  logic             w_neg;
  logic [OUT_W-1:0] w_max;
  logic [OUT_W-1:0] w_min;

  assign w_neg = i_acc[ACC_W-1] ^ i_wrap;
  assign w_max = {1'b0, {(OUT_W-1){1'b1}}};
  assign w_min = {1'b1, {(OUT_W-1){1'b0}}};

  always_comb begin
    o_result = i_acc[OUT_W-1:0];
    if (o_ovf) begin
      o_result = w_neg ? w_min : w_max;
    end
  end
`else
  assign o_result = i_acc[OUT_W-1:0];
`endif

endmodule

// File: rtl/booth_mac_acc.sv
// booth_mac_acc
//   Accumulates a burst of signed products delimited by first/last markers
//   and presents one registered result on a valid/ready output.
//   Optional macro: BOOTH_MAC_SAT_EN (see booth_acc_narrow).
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both 1; the sender holds its payload stable while valid=1 and ready=0.
//   in_ready depends only on FSM state (no path from out_ready).
//   Ports:
//     clk, rst                  clock, async active-high reset
//     in_valid/in_ready         product beat handshake
//     in_product [PROD_W-1:0]   signed product
//     in_first, in_last         burst delimiters
//     out_valid/out_ready       result handshake
//     out_result [OUT_W-1:0]    accumulated result
//     out_count  [CNT_W-1:0]    number of terms (saturating)
//     out_ovf                   result not exactly representable
//     dbg_state                 current FSM state (debug)
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter int PROD_W = BOOTH_PROD_W,
  parameter int ACC_W  = 80,
  parameter int OUT_W  = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_result,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output state_t            dbg_state
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_wrap;
  logic [OUT_W-1:0]   r_out_result;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovf;

  logic               w_accept;
  logic               w_load;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_sum;
  logic               w_add_ovf;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_wrap_nxt;
  logic [OUT_W-1:0]   w_narrow_result;
  logic               w_narrow_ovf;

  assign in_ready  = (r_state != OUT);
  assign out_valid = (r_state == OUT);
  assign w_accept  = in_valid && in_ready;
  assign dbg_state = r_state;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_accept) begin
          w_state_nxt = in_last ? OUT : ACCUM;
        end
      end
      OUT: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- Datapath ----------------
  // A beat in IDLE always starts a burst; in_first in ACCUM restarts it.
  assign w_load     = (r_state == IDLE) || in_first;
  assign w_prod_ext = ACC_W'($signed(in_product));
  assign w_sum      = r_acc + w_prod_ext;
  assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

  assign w_acc_nxt   = w_load ? w_prod_ext : w_sum;
  assign w_count_nxt = w_load ? CNT_W'(1)
                              : ((&r_count) ? r_count : r_count + CNT_W'(1));
  assign w_wrap_nxt  = w_load ? 1'b0 : (r_wrap | w_add_ovf);

  // Narrowing sees the accumulator value including the current beat, so the
  // result registers can load on the same edge that accepts the last beat.
  booth_acc_narrow #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_narrow (
    .i_acc    (w_acc_nxt),
    .i_wrap   (w_wrap_nxt),
    .o_result (w_narrow_result),
    .o_ovf    (w_narrow_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc        <= '0;
      r_count      <= '0;
      r_wrap       <= 1'b0;
      r_out_result <= '0;
      r_out_count  <= '0;
      r_out_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
      if (in_last) begin
        r_out_result <= w_narrow_result;
        r_out_count  <= w_count_nxt;
        r_out_ovf    <= w_narrow_ovf;
      end
    end
  end

  assign out_result = r_out_result;
  assign out_count  = r_out_count;
  assign out_ovf    = r_out_ovf;

endmodule

// File: tb/tb_booth_mac_acc.sv
// tb_booth_mac_acc
//   Directed bench for booth_mac_acc. Inputs are driven and outputs sampled
//   on the falling clock edge; the DUT captures on the rising edge.
module tb_booth_mac_acc;
  import booth_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_product;
  logic         in_first;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_result;
  logic [15:0]  out_count;
  logic         out_ovf;
  state_t       dbg_state;

  int checks   = 0;
  int failures = 0;

  booth_mac_acc dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_first   (in_first),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_count  (out_count),
    .out_ovf    (out_ovf),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a falling edge; presents one beat for exactly one rising edge
  // and returns at the following falling edge with in_valid low.
  task automatic beat(input logic [63:0] p, input logic f, input logic l);
    in_valid   = 1'b1;
    in_product = p;
    in_first   = f;
    in_last    = l;
    @(negedge clk);
    in_valid   = 1'b0;
    in_product = 'x;
    in_first   = 1'b0;
    in_last    = 1'b0;
  endtask

  // Accept the pending result and check the one-cycle return to IDLE.
  task automatic take(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_post_ready"}, 64'(in_ready), 64'd1);
  endtask

  logic [63:0] exp_ovf_result;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_product = '0;
    in_first   = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
`ifdef BOOTH_MAC_SAT_EN
    exp_ovf_result = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    exp_ovf_result = 64'hFFFF_FFFF_FFFF_FFFE;
`endif

    // ---- reset state ----
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid",  64'(out_valid), 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_count",  64'(out_count), 64'd0);
    chk("rst_ovf",    64'(out_ovf), 64'd0);
    chk("rst_ready",  64'(in_ready), 64'd1);
    chk("rst_state",  64'(dbg_state), 64'(IDLE));

    // ---- single term -6 ----
    beat(-64'sd6, 1'b1, 1'b1);
    chk("single_valid",  64'(out_valid), 64'd1);
    chk("single_result", out_result, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("single_count",  64'(out_count), 64'd1);
    chk("single_ovf",    64'(out_ovf), 64'd0);
    chk("single_ready",  64'(in_ready), 64'd0);
    take("single");

    // ---- burst 10, -3, 7 with idle gaps = 14 ----
    beat(64'd10, 1'b1, 1'b0);
    chk("burst_mid_ready", 64'(in_ready), 64'd1);
    chk("burst_mid_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    beat(-64'sd3, 1'b0, 1'b0);
    @(negedge clk);
    beat(64'd7, 1'b0, 1'b1);
    chk("burst_valid",  64'(out_valid), 64'd1);
    chk("burst_result", out_result, 64'd14);
    chk("burst_count",  64'(out_count), 64'd3);
    chk("burst_ovf",    64'(out_ovf), 64'd0);

    // ---- backpressure: 5 cycles, a stray beat offered must be ignored ----
    in_valid   = 1'b1;
    in_product = 64'd123;
    in_first   = 1'b1;
    in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid",  64'(out_valid), 64'd1);
      chk("bp_result", out_result, 64'd14);
      chk("bp_count",  64'(out_count), 64'd3);
      chk("bp_ready",  64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    take("bp");

    // ---- restart: 100, 200, first 5, last 1 = 6, count 2 ----
    beat(64'd100, 1'b1, 1'b0);
    beat(64'd200, 1'b0, 1'b0);
    beat(64'd5,   1'b1, 1'b0);
    beat(64'd1,   1'b0, 1'b1);
    chk("restart_result", out_result, 64'd6);
    chk("restart_count",  64'(out_count), 64'd2);
    chk("restart_ovf",    64'(out_ovf), 64'd0);
    take("restart");

    // ---- overflow: max + max ----
    beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    chk("ovf_flag",   64'(out_ovf), 64'd1);
    chk("ovf_result", out_result, exp_ovf_result);
    chk("ovf_count",  64'(out_count), 64'd2);
    take("ovf");

    // ---- reset mid-burst (outputs still hold the overflow result) ----
    beat(64'd3, 1'b1, 1'b0);
    beat(64'd4, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_state",  64'(dbg_state), 64'(IDLE));
    chk("mrst_result", out_result, 64'd0);
    chk("mrst_count",  64'(out_count), 64'd0);
    chk("mrst_ovf",    64'(out_ovf), 64'd0);
    chk("mrst_valid",  64'(out_valid), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_ready", 64'(in_ready), 64'd1);
    // in_first is ignored in IDLE: this beat still starts a fresh burst.
    beat(64'd9, 1'b0, 1'b1);
    chk("after_rst_result", out_result, 64'd9);
    chk("after_rst_count",  64'(out_count), 64'd1);
    chk("after_rst_ovf",    64'(out_ovf), 64'd0);
    take("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
